// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_bank divider bank.
// Optional build macro: CLK_DIV_ODD_DUTY_EN (50% duty for odd divisors).
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } ch_state_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, start/stop FSM, pending/active divisor.
// Optional build macro: CLK_DIV_ODD_DUTY_EN adds a negedge stage for 50% duty on odd N.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 10
) (
  input  logic             clk_in,
  input  logic             rst_b,
  input  logic             i_run_req,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_clk,
  output logic             o_running
);

  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] r_div;
  logic             r_clk;

  logic             w_wrap;
  logic             w_stop_done;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] w_div_sel;

  assign w_wrap      = (r_state != IDLE) && (r_cnt == r_div - CNT_W'(1));
  assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + CNT_W'(1);
  assign w_half      = r_div >> 1;
  // A write landing on a boundary edge wins over the pending copy.
  assign w_div_sel   = i_wr ? i_div : r_pend;
  assign w_stop_done = (w_state_nxt == IDLE) && (r_state == STOPPING);

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (i_run_req) w_state_nxt = RUN;
      RUN:      if (!i_run_req) w_state_nxt = STOPPING;
      STOPPING: begin
        if (i_run_req)   w_state_nxt = RUN;
        else if (w_wrap) w_state_nxt = IDLE;
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_pend <= CNT_W'(DEF_DIV);
      r_div  <= CNT_W'(DEF_DIV);
    end else begin
      if (i_wr) r_pend <= i_div;
      if (r_state == IDLE) begin
        r_div <= w_div_sel;
        r_cnt <= '0;
        r_clk <= i_run_req;
      end else begin
        r_cnt <= w_cnt_nxt;
        if (w_wrap) r_div <= w_div_sel;
        // Every N>=2 has H>=1, so count 0 is always in the high phase.
        r_clk <= w_stop_done ? 1'b0 : (w_cnt_nxt < w_half);
      end
    end
  end

`ifdef CLK_DIV_ODD_DUTY_EN
  logic r_clk_neg;

  always_ff @(negedge clk_in or negedge rst_b) begin
    if (!rst_b) r_clk_neg <= 1'b0;
    else        r_clk_neg <= r_clk;
  end

  always_comb begin
    o_running = (r_state != IDLE);
    o_clk     = r_clk | (r_div[0] & r_clk_neg);
  end
`else
  always_comb begin
    o_running = (r_state != IDLE);
    o_clk     = r_clk;
  end
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH glitch-free integer clock dividers with runtime divisor writes.
// Optional build macro: CLK_DIV_ODD_DUTY_EN (50% duty for odd divisors).
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = 8,
  parameter  int DEF_DIV = 10,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_b,
  input  logic              stop,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] running
);

  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_wr;
  logic              w_div_ok;
  logic              w_reject;
  logic              r_err;

  assign w_div_ok = (cfg_div >= CNT_W'(MIN_DIV));
  // Out-of-range channel numbers match no decode line, so they reject.
  assign w_reject = cfg_wr && !((|w_hit) && w_div_ok);
  assign cfg_err  = r_err;

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) r_err <= 1'b0;
    else        r_err <= w_reject;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_hit[g] = (cfg_ch == CH_W'(g));
    assign w_wr[g]  = cfg_wr && w_hit[g] && w_div_ok;

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_in    (clk_in),
      .rst_b     (rst_b),
      .i_run_req (ch_en[g] & ~stop),
      .i_wr      (w_wr[g]),
      .i_div     (cfg_div),
      .o_clk     (clk_out[g]),
      .o_running (running[g])
    );
  end

endmodule
